// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter bundle for uart_tx_arbiter: request side from the byte producers,
// transmit side towards uart_send.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_trigger;
    logic                 busy;
    logic [GW-1:0]        grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ack, tx_data, tx_trigger, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ack, tx_data, tx_trigger, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send among NUM_REQ byte producers; frames are timed
// internally. Optional UART_ARB_STATS_EN adds a saturating frame_count output.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter real         clkFreq      = 12e6,
    parameter real         baudRate     = 115200.0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef UART_ARB_STATS_EN
    output logic [15:0]      frame_count,
`endif
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BIT_CYCLES   = $rtoi(clkFreq / baudRate);
    localparam int unsigned FRAME_CYCLES = BIT_CYCLES * (9 + STOP_BITS) + GUARD_CYCLES;
    localparam int unsigned CW           = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {StHoldoff, StIdle, StTrigger, StWait} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   scan_idx;
    logic [7:0]      win_data;

    // Rotating priority: search starts just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = bus.grant_id;
        scan_idx  = '0;
        win_data  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = GW'((32'(bus.grant_id) + i) % NUM_REQ);
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win_idx == GW'(j)) begin
                win_data = bus.req_data[8*j +: 8];
            end
        end
    end

    assign bus.busy = (state_q != StIdle);

    // Counter values are chosen so that triggers under continuous demand land exactly
    // FRAME_CYCLES apart (TRIGGER + WAIT + the granting IDLE edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StHoldoff;
            cnt_q          <= CW'(FRAME_CYCLES - 1);
            bus.req_ack    <= '0;
            bus.tx_trigger <= 1'b0;
            bus.tx_data    <= '0;
            bus.grant_id   <= GW'(NUM_REQ - 1);
        end else begin
            bus.req_ack    <= '0;
            bus.tx_trigger <= 1'b0;
            unique case (state_q)
                StHoldoff, StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StIdle: begin
                    if (win_found) begin
                        bus.tx_data    <= win_data;
                        bus.grant_id   <= win_idx;
                        bus.req_ack    <= NUM_REQ'(1) << win_idx;
                        bus.tx_trigger <= 1'b1;
                        state_q        <= StTrigger;
                    end
                end
                StTrigger: begin
                    state_q <= StWait;
                    cnt_q   <= CW'(FRAME_CYCLES - 3);
                end
                default: state_q <= StHoldoff;
            endcase
        end
    end

`ifdef UART_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (state_q == StTrigger && frame_count != 16'hFFFF) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`else
    // Statistics disabled: no frame counter in this build.
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus scoreboard of expected grants,
// with scripted sequences for back-to-back demand, late requests and mid-frame reset.
module tb_uart_tx_arbiter;
    localparam int unsigned F = 102;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
        logic [3:0] ack;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [7:0]  exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef UART_ARB_STATS_EN
    logic [15:0] frame_count;
`endif

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .clkFreq     (12e6),
        .baudRate    (1.2e6),
        .STOP_BITS   (1),
        .GUARD_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_ARB_STATS_EN
        .frame_count(frame_count),
`endif
        .bus        (bus)
    );

    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_err      = 0;
    int   trig_count = 0;
    bit   mon_en     = 1'b0;
    int   trig_cyc[$];
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every trigger must match the oldest outstanding expected grant.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && bus.tx_trigger === 1'b1) begin
            trig_count++;
            trig_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_trigger: got tx_data=0x%0h, expected no trigger",
                         bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                check("trig_tx_data", 32'(bus.tx_data), 32'(e.data));
                check("trig_grant_id", 32'(bus.grant_id), 32'(e.id));
                check("trig_req_ack", 32'(bus.req_ack), 32'(e.ack));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_ack == '0 && n < budget);
        if (bus.req_ack == '0) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_ack_timeout: got no ack in %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_trigs(input int target, input int budget);
        int n = 0;
        while (trig_count < target && n < budget) begin
            tick();
            n++;
        end
        if (trig_count < target) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_trig_timeout: got %0d triggers, expected %0d", trig_count, target);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vecs[7];
        int   hold_bad;
        int   busy_len;
        int   base;
        int   ntrig0;

        vecs[0] = '{4'b0001, 32'h0000_0041, 8'h41, 2'd0};
        vecs[1] = '{4'b0110, 32'h00B2_B100, 8'hB1, 2'd1};
        vecs[2] = '{4'b0110, 32'h00C2_C100, 8'hC2, 2'd2};
        vecs[3] = '{4'b1001, 32'hD300_00D0, 8'hD3, 2'd3};
        vecs[4] = '{4'b1001, 32'hE300_00E0, 8'hE0, 2'd0};
        vecs[5] = '{4'b0100, 32'h00F2_0000, 8'hF2, 2'd2};
        vecs[6] = '{4'b1000, 32'h3700_0000, 8'h37, 2'd3};

        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset and holdoff
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        check("rst_tx_trigger", 32'(bus.tx_trigger), 32'd0);
        check("rst_req_ack", 32'(bus.req_ack), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd3);
        check("rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        hold_bad = 0;
        for (int k = 1; k < int'(F); k++) begin
            tick();
            if (!bus.busy) hold_bad++;
        end
        check("holdoff_busy_drops", 32'(hold_bad), 32'd0);
        tick();
        check("holdoff_idle", 32'(bus.busy), 32'd0);
        check("holdoff_no_trigger", 32'(trig_count), 32'd0);

        // Table-driven single grants
        for (int v = 0; v < 7; v++) begin
            wait_idle(2 * F);
            bus.req_data  = vecs[v].data;
            bus.req_valid = vecs[v].valid;
            exp_q.push_back('{vecs[v].exp_data, vecs[v].exp_id, 4'b0001 << vecs[v].exp_id});
            tick();
            bus.req_valid = '0;
            busy_len = 0;
            while (bus.busy && busy_len < 2 * int'(F)) begin
                busy_len++;
                tick();
            end
            check("busy_length", 32'(busy_len), 32'(F - 1));
            check("tx_data_hold", 32'(bus.tx_data), 32'(vecs[v].exp_data));
            check("grant_id_hold", 32'(bus.grant_id), 32'(vecs[v].exp_id));
        end

        // All four pending continuously: strict rotation, FRAME_CYCLES spacing
        wait_idle(2 * F);
        base = trig_cyc.size();
        bus.req_data  = 32'h4030_2010;
        bus.req_valid = 4'b1111;
        exp_q.push_back('{8'h10, 2'd0, 4'b0001});
        exp_q.push_back('{8'h20, 2'd1, 4'b0010});
        exp_q.push_back('{8'h30, 2'd2, 4'b0100});
        exp_q.push_back('{8'h40, 2'd3, 4'b1000});
        exp_q.push_back('{8'h10, 2'd0, 4'b0001});
        wait_trigs(trig_count + 5, 6 * F);
        bus.req_valid = '0;
        for (int k = 1; k < 5; k++) begin
            if (trig_cyc.size() > base + k) begin
                check("trigger_spacing", 32'(trig_cyc[base+k] - trig_cyc[base+k-1]), 32'(F));
            end else begin
                n_checks++;
                n_err++;
                $display("FAIL trigger_spacing: got %0d triggers, expected %0d",
                         trig_cyc.size() - base, k + 1);
            end
        end
        wait_idle(2 * F);

        // Requester 2 holds valid; requester 0 arrives mid-WAIT each frame
        bus.req_data  = 32'h00C2_00C0;
        bus.req_valid = 4'b0100;
        exp_q.push_back('{8'hC2, 2'd2, 4'b0100});
        for (int i = 0; i < 4; i++) begin
            wait_ack(2 * F);
            if (bus.req_ack[0]) bus.req_valid[0] = 1'b0;
            repeat (50) tick();
            bus.req_valid[0] = 1'b1;
            if (i % 2 == 0) exp_q.push_back('{8'hC0, 2'd0, 4'b0001});
            else            exp_q.push_back('{8'hC2, 2'd2, 4'b0100});
        end
        wait_ack(2 * F);

        // Reset 50 cycles into a WAIT while requester 0 stays pending
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_005A;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx_trigger", 32'(bus.tx_trigger), 32'd0);
        check("midrst_req_ack", 32'(bus.req_ack), 32'd0);
        check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
        check("midrst_grant_id", 32'(bus.grant_id), 32'd3);
        ntrig0 = trig_count;
        repeat (F) tick();
        check("midrst_no_trigger", 32'(trig_count - ntrig0), 32'd0);
        check("midrst_trigger_low", 32'(bus.tx_trigger), 32'd0);
        exp_q.push_back('{8'h5A, 2'd0, 4'b0001});
        tick();
        check("midrst_trigger_after", 32'(bus.tx_trigger), 32'd1);
        bus.req_valid = '0;
        wait_idle(2 * F);

`ifdef UART_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fc_reset", 32'(frame_count), 32'd0);
        wait_idle(2 * F);
        bus.req_data  = 32'h0000_7700;
        bus.req_valid = 4'b0010;
        repeat (3) exp_q.push_back('{8'h77, 2'd1, 4'b0010});
        wait_trigs(trig_count + 3, 4 * F);
        bus.req_valid = '0;
        repeat (2) tick();
        check("fc_three", 32'(frame_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fc_cleared", 32'(frame_count), 32'd0);
        wait_idle(2 * F);
`endif

        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
